// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and the IF/ID register.
// FWFT buffer of {instr, pc_plus4}; flush empties it in one cycle.
module inst_fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_instr,
  input  logic [ADDR_WIDTH-1:0] wr_pc_plus4,
  output logic                  wr_ready,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_instr,
  output logic [ADDR_WIDTH-1:0] rd_pc_plus4,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  drop_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 drop_err_q, drop_err_d;
  logic                 push, pop;

  // Status and head outputs; an empty queue presents a NOP bubble.
  always_comb begin
    wr_ready    = (count_q != CNT_WIDTH'(DEPTH));
    rd_valid    = (count_q != '0);
    rd_instr    = '0;
    rd_pc_plus4 = '0;
    if (rd_valid) begin
      rd_instr    = instr_mem_q[rd_ptr_q];
      rd_pc_plus4 = pc_mem_q[rd_ptr_q];
    end
    count    = count_q;
    drop_err = drop_err_q;
  end

  // Next-state: flush beats push/pop; full writes are dropped and flagged.
  always_comb begin
    push       = wr_valid & wr_ready & ~flush;
    pop        = rd_ready & rd_valid & ~flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    if (wr_valid & ~wr_ready & ~flush) begin
      drop_err_d = 1'b1;
    end
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push & ~pop) begin
        count_d = count_q + CNT_WIDTH'(1);
      end else if (pop & ~push) begin
        count_d = count_q - CNT_WIDTH'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push & ~reset) begin
      instr_mem_q[wr_ptr_q] <= wr_instr;
      pc_mem_q[wr_ptr_q]    <= wr_pc_plus4;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based model checked every
// cycle plus directed literal expectations.
module tb_inst_fetch_queue;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, flush, wr_valid, rd_ready;
  logic [DW-1:0] wr_instr;
  logic [AW-1:0] wr_pc_plus4;
  logic          wr_ready, rd_valid, drop_err;
  logic [DW-1:0] rd_instr;
  logic [AW-1:0] rd_pc_plus4;
  logic [CW-1:0] count;

  int checks = 0;
  int fails  = 0;

  inst_fetch_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_instr(wr_instr),
    .wr_pc_plus4(wr_pc_plus4), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_instr(rd_instr), .rd_pc_plus4(rd_pc_plus4),
    .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t mq[$];
  bit   m_drop = 0;
  bit   m_live = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Model: FIFO semantics straight from the rules.
  always @(posedge clk) begin
    bit full, do_pop, do_push;
    full    = (mq.size() == DEPTH);
    do_pop  = rd_ready && (mq.size() > 0);
    do_push = wr_valid && !full;
    if (reset) begin
      mq.delete();
      m_drop = 0;
      m_live = 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (wr_valid && full) m_drop = 1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{wr_instr, wr_pc_plus4});
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_rd_valid", 64'(rd_valid), 64'(mq.size() > 0));
      chk("m_wr_ready", 64'(wr_ready), 64'(mq.size() < DEPTH));
      chk("m_drop_err", 64'(drop_err), 64'(m_drop));
      chk("m_rd_instr", 64'(rd_instr),
          mq.size() > 0 ? 64'(mq[0].instr) : 64'd0);
      chk("m_rd_pc", 64'(rd_pc_plus4),
          mq.size() > 0 ? 64'(mq[0].pc) : 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string nm, input logic v,
                      input logic [DW-1:0] i, input logic [AW-1:0] p,
                      input int c);
    chk({nm, "_valid"}, 64'(rd_valid), 64'(v));
    chk({nm, "_instr"}, 64'(rd_instr), 64'(i));
    chk({nm, "_pc"}, 64'(rd_pc_plus4), 64'(p));
    chk({nm, "_count"}, 64'(count), 64'(c));
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    reset = 1; flush = 0; wr_valid = 0; rd_ready = 0;
    wr_instr = '0; wr_pc_plus4 = '0;
    step(); reset = 0;

    // Reset then idle
    head("rst", 0, 0, 0, 0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_drop", 64'(drop_err), 64'd0);
    step();
    head("idle", 0, 0, 0, 0);

    // Two pushes, then drain in order
    wr_valid = 1; wr_instr = 32'h20080005; wr_pc_plus4 = 10'd4;
    step();
    head("p1", 1, 32'h20080005, 4, 1);
    wr_instr = 32'h20090007; wr_pc_plus4 = 10'd8;
    step();
    head("p2", 1, 32'h20080005, 4, 2);
    wr_valid = 0; rd_ready = 1;
    step();
    head("d1", 1, 32'h20090007, 8, 1);
    step();
    head("d2", 0, 0, 0, 0);
    rd_ready = 0;

    // Fill, then overflow attempts
    wr_valid = 1;
    for (int k = 0; k < DEPTH; k++) begin
      wr_instr = 32'hA000_0000 + k; wr_pc_plus4 = AW'(100 + 4 * k);
      step();
    end
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    wr_instr = 32'hDEADBEEF; wr_pc_plus4 = 10'd0;
    step(); step();
    chk("ovf_drop", 64'(drop_err), 64'd1);
    head("ovf", 1, 32'hA000_0000, 100, 4);
    wr_valid = 0; rd_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_instr", 64'(rd_instr), 64'(32'hA000_0000 + k));
      chk("drain_pc", 64'(rd_pc_plus4), 64'(100 + 4 * k));
      step();
    end
    head("drained", 0, 0, 0, 0);
    chk("drop_sticky", 64'(drop_err), 64'd1);
    do_reset();
    chk("drop_clr", 64'(drop_err), 64'd0);

    // Streaming push+pop across pointer wrap
    rd_ready = 1; wr_valid = 1;
    for (int k = 1; k <= 10; k++) begin
      wr_instr = 32'h1000 + k; wr_pc_plus4 = AW'(4 * k);
      step();
      head("strm", 1, 32'h1000 + k, AW'(4 * k), 1);
    end
    wr_valid = 0;
    step();
    head("strm_end", 0, 0, 0, 0);
    chk("strm_drop", 64'(drop_err), 64'd0);

    // Flush with concurrent write and read
    rd_ready = 0; wr_valid = 1;
    for (int k = 0; k < 3; k++) begin
      wr_instr = 32'hB000_0000 + k; wr_pc_plus4 = AW'(200 + 4 * k);
      step();
    end
    chk("pre_flush_cnt", 64'(count), 64'd3);
    flush = 1; rd_ready = 1; wr_instr = 32'hCAFE0000;
    step();
    head("flush", 0, 0, 0, 0);
    flush = 0; rd_ready = 0;
    wr_instr = 32'h08000010; wr_pc_plus4 = 10'd20;
    step();
    head("post_flush", 1, 32'h08000010, 20, 1);
    wr_valid = 0; rd_ready = 1;
    step();
    head("post_flush_d", 0, 0, 0, 0);

    // Reset with full queue, flush and write asserted
    rd_ready = 0; wr_valid = 1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      wr_instr = 32'hC000_0000 + k; wr_pc_plus4 = AW'(300 + 4 * k);
      step();
    end
    chk("pre_rst_drop", 64'(drop_err), 64'd1);
    reset = 1; flush = 1; rd_ready = 1;
    step();
    reset = 0; flush = 0; wr_valid = 0; rd_ready = 0;
    head("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("mid_rst_drop", 64'(drop_err), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
